sb_serializer: RTL and testbench

SB_SERIALIZER -- requirements
Module: sb_serializer

---
 rtl/sb_serializer.sv | 115 +++++++++++
 tb/tb_sb_serializer.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sb_serializer.sv
// Sideband serializer: pops one packet word from the TX FIFO, shifts it out LSB first,
// then enforces a fixed idle gap before the next packet may start.
module sb_serializer #(
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned GAP_CYCLES = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [DATA_W-1:0] i_fifo_data,
  input  logic              i_fifo_empty,
  input  logic              i_clk_ser_en,
  output logic              o_fifo_rd_en,
  output logic              o_txdata_sb,
  output logic              o_clk_gate_en,
  output logic              o_ser_done,
  output logic              o_busy
);

  localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
  localparam logic [GAP_W-1:0] LAST_GAP = GAP_W'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  sr_q, sr_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic               gate_q, gate_d;
  logic               txd_q, txd_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;
  logic               gap_last;
  logic               pop;

  // State and datapath registers; reset clears everything immediately.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      sr_q      <= '0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      gate_q    <= 1'b0;
      txd_q     <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      gate_q    <= gate_d;
      txd_q     <= txd_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  // Next-state, datapath update and next values of the registered outputs.
  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;

    gap_last = (state_q == S_GAP) && (gap_cnt_q == LAST_GAP);
    // Pop only from IDLE or on the last gap cycle, so a packet in flight is never disturbed.
    pop = !i_rst && i_clk_ser_en && !i_fifo_empty && ((state_q == S_IDLE) || gap_last);

    case (state_q)
      S_IDLE: begin
        if (pop) state_d = S_LOAD;
      end
      S_LOAD: begin
        sr_d      = i_fifo_data;
        bit_cnt_d = '0;
        state_d   = S_SHIFT;
      end
      S_SHIFT: begin
        sr_d = sr_q >> 1;
        if (bit_cnt_q == LAST_BIT) begin
          bit_cnt_d = '0;
          gap_cnt_d = '0;
          state_d   = S_GAP;
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      S_GAP: begin
        if (gap_last) state_d = pop ? S_LOAD : S_IDLE;
        else          gap_cnt_d = gap_cnt_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered from the next state so they move on the same edges as the FSM.
    gate_d = (state_d == S_SHIFT);
    txd_d  = (state_d == S_SHIFT) ? sr_d[0] : 1'b0;
    done_d = (state_d == S_GAP) && (gap_cnt_d == LAST_GAP);
    busy_d = (state_d != S_IDLE);
  end

  assign o_fifo_rd_en  = pop;
  assign o_txdata_sb   = txd_q;
  assign o_clk_gate_en = gate_q;
  assign o_ser_done    = done_q;
  assign o_busy        = busy_q;

endmodule

// File: tb/tb_sb_serializer.sv
// Directed bench for sb_serializer: table of single-packet vectors plus hand-written
// back-to-back, empty-gating, reset-abort and narrow-parameter sequences.
module tb_sb_serializer;

  localparam int unsigned DW   = 64;
  localparam int unsigned GAP  = 32;
  localparam int unsigned DW2  = 32;
  localparam int unsigned GAP2 = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Simple FIFO model: words pushed by the stimulus, popped on rd_en, data valid next cycle.
  logic [63:0] mem [0:15];
  int          push_cnt = 0;
  int          pop_cnt  = 0;
  logic        fake_full;
  logic [63:0] fifo_data = '0;
  logic        empty;
  logic        en;
  logic        rd_en, txd, gate, done, busy;

  assign empty = (push_cnt == pop_cnt) && !fake_full;

  always @(posedge clk) begin
    if (rd_en) begin
      fifo_data <= mem[pop_cnt % 16];
      pop_cnt   <= pop_cnt + 1;
    end
  end

  sb_serializer #(.DATA_W(DW), .GAP_CYCLES(GAP)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_fifo_data  (fifo_data),
    .i_fifo_empty (empty),
    .i_clk_ser_en (en),
    .o_fifo_rd_en (rd_en),
    .o_txdata_sb  (txd),
    .o_clk_gate_en(gate),
    .o_ser_done   (done),
    .o_busy       (busy)
  );

  logic [31:0] data32;
  logic        empty32, en32;
  logic        rd_en32, txd32, gate32, done32, busy32;

  sb_serializer #(.DATA_W(DW2), .GAP_CYCLES(GAP2)) dut32 (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_fifo_data  (data32),
    .i_fifo_empty (empty32),
    .i_clk_ser_en (en32),
    .o_fifo_rd_en (rd_en32),
    .o_txdata_sb  (txd32),
    .o_clk_gate_en(gate32),
    .o_ser_done   (done32),
    .o_busy       (busy32)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic push(input logic [63:0] w);
    mem[push_cnt % 16] = w;
    push_cnt++;
  endtask

  // Waits (bounded) for the pop strobe; returns 1 if it was seen.
  task automatic wait_rd(input string tag, output bit seen);
    int k;
    k = 0;
    while (!rd_en && k < 20) begin
      tick();
      k++;
    end
    seen = rd_en;
    chk({tag, ".rd_en_seen"}, 64'(seen), 64'd1);
  endtask

  task automatic run_packet(input logic [63:0] word, input int drop_at,
                            input logic [15:0] exp_low16, input int exp_ones, input string tag);
    logic [63:0] cap;
    int          p0, gate_bad, gap, gap_bad, extra;
    bit          seen;
    cap      = '0;
    gate_bad = 0;
    p0       = pop_cnt;
    push(word);
    #1;
    wait_rd(tag, seen);
    if (!seen) return;
    tick();
    chk({tag, ".load"}, {60'd0, rd_en, gate, txd, busy}, 64'h1);
    tick();
    chk({tag, ".first_ui_gate"}, 64'(gate), 64'd1);
    for (int i = 0; i < int'(DW); i++) begin
      if (i > 0) tick();
      if (!gate || !busy || rd_en) gate_bad++;
      cap[i] = txd;
      if (i == drop_at) begin
        en        = 1'b0;
        fake_full = 1'b1;
      end
    end
    chk({tag, ".gate_window"}, 64'(gate_bad), 64'd0);
    chk({tag, ".word"}, cap, word);
    chk({tag, ".low16"}, 64'(cap[15:0]), 64'(exp_low16));
    chk({tag, ".ones"}, 64'($countones(cap)), 64'(exp_ones));
    gap     = 0;
    gap_bad = 0;
    do begin
      tick();
      gap++;
      if (gate || txd || !busy) gap_bad++;
    end while (!done && gap < 100);
    chk({tag, ".gap_len"}, 64'(gap), 64'(GAP));
    chk({tag, ".gap_quiet"}, 64'(gap_bad), 64'd0);
    tick();
    chk({tag, ".idle_after"}, {61'd0, busy, done, gate}, 64'd0);
    chk({tag, ".pops"}, 64'(pop_cnt - p0), 64'd1);
    if (drop_at >= 0) begin
      extra = 0;
      repeat (10) begin
        if (rd_en || busy) extra++;
        tick();
      end
      chk({tag, ".no_pop_when_disabled"}, 64'(extra), 64'd0);
      en        = 1'b1;
      fake_full = 1'b0;
    end
  endtask

  typedef struct {
    logic [63:0] word;
    int          drop_at;
    logic [15:0] exp_low16;
    int          exp_ones;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int          bad, first_end, second_start, done_cyc, cyc, pk, bi;
    int          rd_cycles [$];
    logic        prev_gate;
    logic [63:0] cap2 [2];
    logic [31:0] cap32;
    bit          seen;

    vecs[0] = '{64'hA5A5_0000_FFFF_1234, -1, 16'h1234, 29};
    vecs[1] = '{64'h0000_0000_0000_0001, -1, 16'h0001, 1};
    vecs[2] = '{64'h8000_0000_0000_0000, -1, 16'h0000, 1};
    vecs[3] = '{64'hFFFF_FFFF_FFFF_FFFF, -1, 16'hFFFF, 64};
    vecs[4] = '{64'hDEAD_BEEF_0123_4567, 10, 16'h4567, 36};

    // Reset with a pop apparently possible: everything must stay low.
    rst       = 1'b1;
    en        = 1'b1;
    fake_full = 1'b1;
    en32      = 1'b1;
    empty32   = 1'b1;
    data32    = 32'h8000_0001;
    tick();
    chk("reset.outputs", {59'd0, rd_en, txd, gate, done, busy}, 64'd0);
    chk("reset.outputs32", {59'd0, rd_en32, txd32, gate32, done32, busy32}, 64'd0);
    fake_full = 1'b0;
    tick();
    rst = 1'b0;
    tick();

    for (int v = 0; v < 5; v++)
      run_packet(vecs[v].word, vecs[v].drop_at, vecs[v].exp_low16, vecs[v].exp_ones,
                 $sformatf("vec%0d", v));

    // Empty FIFO with enable high: nothing may start.
    bad = 0;
    repeat (100) begin
      if (rd_en || busy || gate) bad++;
      tick();
    end
    chk("empty_gating", 64'(bad), 64'd0);

    // Back-to-back packets: second pop on the final gap cycle, 33 non-data cycles between.
    push(64'h1111_2222_3333_4444);
    push(64'hCAFE_F00D_8765_4321);
    #1;
    first_end    = -1;
    second_start = -1;
    done_cyc     = -1;
    prev_gate    = 1'b0;
    pk           = -1;
    bi           = 0;
    cap2[0]      = '0;
    cap2[1]      = '0;
    for (cyc = 0; cyc < 300; cyc++) begin
      if (rd_en) rd_cycles.push_back(cyc);
      if (done && done_cyc < 0) done_cyc = cyc;
      if (prev_gate && !gate && first_end < 0) first_end = cyc - 1;
      if (!prev_gate && gate) begin
        pk++;
        bi = 0;
        if (first_end >= 0 && second_start < 0) second_start = cyc;
      end
      if (gate && pk >= 0 && pk < 2 && bi < 64) begin
        cap2[pk][bi] = txd;
        bi++;
      end
      prev_gate = gate;
      tick();
    end
    chk("b2b.pop_count", 64'(rd_cycles.size()), 64'd2);
    if (rd_cycles.size() == 2)
      chk("b2b.second_pop_on_done", 64'(rd_cycles[1]), 64'(done_cyc));
    chk("b2b.non_data_cycles", 64'(second_start - first_end - 1), 64'(GAP + 1));
    chk("b2b.word0", cap2[0], 64'h1111_2222_3333_4444);
    chk("b2b.word1", cap2[1], 64'hCAFE_F00D_8765_4321);
    chk("b2b.idle_end", 64'(busy), 64'd0);

    // Reset during SHIFT at bit 30: immediate clear, no done, nothing re-sent.
    push(64'h7777_7777_7777_7777);
    #1;
    wait_rd("rst_abort", seen);
    tick();
    tick();
    repeat (30) tick();
    rst = 1'b1;
    #1;
    chk("rst_abort.immediate", {59'd0, rd_en, txd, gate, done, busy}, 64'd0);
    tick();
    tick();
    rst = 1'b0;
    bad = 0;
    repeat (50) begin
      tick();
      if (done || busy || gate || rd_en) bad++;
    end
    chk("rst_abort.quiet_after", 64'(bad), 64'd0);
    run_packet(64'h0F0F_F0F0_1357_9BDF, -1, 16'h9BDF, 36, "post_rst");

    // Narrow instance: 32-bit word, 8-cycle gap.
    empty32 = 1'b0;
    #1;
    chk("w32.rd_en", 64'(rd_en32), 64'd1);
    tick();
    empty32 = 1'b0;
    empty32 = 1'b1;
    #1;
    chk("w32.load", {61'd0, rd_en32, gate32, busy32}, 64'd1);
    tick();
    bad   = 0;
    cap32 = '0;
    for (int i = 0; i < int'(DW2); i++) begin
      if (i > 0) tick();
      if (!gate32) bad++;
      cap32[i] = txd32;
    end
    chk("w32.gate_window", 64'(bad), 64'd0);
    chk("w32.word", 64'(cap32), 64'h8000_0001);
    chk("w32.first_last_ui", {62'd0, cap32[31], cap32[0]}, 64'd3);
    cyc = 0;
    bad = 0;
    do begin
      tick();
      cyc++;
      if (gate32 || txd32) bad++;
    end while (!done32 && cyc < 100);
    chk("w32.gap_len", 64'(cyc), 64'(GAP2));
    chk("w32.gap_quiet", 64'(bad), 64'd0);
    tick();
    chk("w32.idle_after", {62'd0, busy32, done32}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
